// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams N_INPUTS (x, w) pairs, clamps the
// running sum to ACC_W bits after every addition, then holds the result for a handshake.
module neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int X_W      = 5,
  parameter int W_W      = 6,
  parameter int ACC_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [X_W-1:0]   x_in,
  input  logic [W_W-1:0]   w_in,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int P_W   = X_W + W_W;
  // Sum is ACC_W+2 wide; widened only if an odd parameter set makes the product wider.
  localparam int SUM_W = (P_W + 1 > ACC_W + 2) ? P_W + 1 : ACC_W + 2;

  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(N_INPUTS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN  = SUM_W'(-(2 ** (ACC_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]         r_sum;

  logic signed [P_W-1:0]    w_prod;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_clamp;
  logic                     w_accept;
  logic                     w_last;

  // x is unsigned (zero-extend), w is two's complement (sign-extend).
  assign w_prod = $signed({{W_W{1'b0}}, x_in}) * $signed({{X_W{w_in[W_W-1]}}, w_in});
  assign w_sum  = SUM_W'(r_acc) + SUM_W'(w_prod);

  always_comb begin
    w_clamp = w_sum[ACC_W-1:0];
    if (w_sum > SAT_MAX)      w_clamp = SAT_MAX[ACC_W-1:0];
    else if (w_sum < SAT_MIN) w_clamp = SAT_MIN[ACC_W-1:0];
  end

  assign w_accept = (r_state == S_ACC) && in_valid;
  assign w_last   = (r_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)              w_next = S_ACC;
      S_ACC:   if (w_accept && w_last) w_next = S_DONE;
      S_DONE:  if (out_ready)          w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_sum <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_clamp;
      if (w_last) r_sum <= w_clamp;
    end
  end

  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum_out   = r_sum;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac at default parameters: latency, saturation,
// per-step clamping, stalls/backpressure and reset aborts.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [4:0]  x_in;
  logic [5:0]  w_in;
  logic        in_ready;
  logic [11:0] sum_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  neuron_mac #(.N_INPUTS(4), .X_W(5), .W_W(6), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .x_in(x_in), .w_in(w_in), .in_ready(in_ready), .sum_out(sum_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed(input logic [4:0] xs[4], input logic [5:0] ws[4],
                      input int gap, input logic pulse_start);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x_in = xs[i]; w_in = ws[i];
      @(negedge clk);
      in_valid = 1'b0; x_in = 5'd31; w_in = 6'd31;
      for (int g = 0; g < gap; g++) begin
        start = pulse_start;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; x_in = 5'd31; w_in = 6'd31; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || sum_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b busy=%b sum=%h expected 0 0 0 000",
               out_valid, in_ready, busy, sum_out);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [4:0] xs[4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    out_ready = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_acc_phase%0d: got ir=%b ov=%b busy=%b expected 1 0 1", i, in_ready, out_valid, busy);
      end
      in_valid = 1'b1; x_in = xs[i]; w_in = 6'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 12'h00A || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_result: got ov=%b sum=%h ir=%b busy=%b expected 1 00a 0 1",
               out_valid, sum_out, in_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== 12'h00A) begin
      n_fail++;
      $display("FAIL basic_one_cycle: got ov=%b busy=%b sum=%h expected 0 0 00a", out_valid, busy, sum_out);
    end
  endtask

  task automatic test_pos_sat();
    logic [4:0] xs[4] = '{5'd31, 5'd31, 5'd31, 5'd31};
    logic [5:0] ws[4] = '{6'd31, 6'd31, 6'd31, 6'd31};
    out_ready = 1'b1;
    do_start();
    feed(xs, ws, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 12'h7FF) begin
      n_fail++; $display("FAIL pos_sat: got ov=%b sum=%h expected 1 7ff", out_valid, sum_out);
    end
    @(negedge clk);
  endtask

  task automatic test_neg_sat();
    logic [4:0] xs[4] = '{5'd31, 5'd31, 5'd31, 5'd31};
    logic [5:0] ws[4] = '{6'h20, 6'h20, 6'h20, 6'h20};
    out_ready = 1'b1;
    do_start();
    feed(xs, ws, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 12'h800) begin
      n_fail++; $display("FAIL neg_sat: got ov=%b sum=%h expected 1 800", out_valid, sum_out);
    end
    @(negedge clk);
  endtask

  task automatic test_per_step_clamp();
    logic [4:0] xs[4] = '{5'd31, 5'd31, 5'd31, 5'd31};
    logic [5:0] ws[4] = '{6'd31, 6'd31, 6'd31, 6'h20};
    out_ready = 1'b1;
    do_start();
    feed(xs, ws, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 12'h41F) begin
      n_fail++; $display("FAIL per_step_clamp: got ov=%b sum=%h expected 1 41f", out_valid, sum_out);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [4:0] xs[4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [5:0] ws[4] = '{6'd1, 6'd1, 6'd1, 6'd1};
    // Pairs presented in IDLE must not land in the accumulator.
    out_ready = 1'b0;
    in_valid = 1'b1; x_in = 5'd31; w_in = 6'd31;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    do_start();
    feed(xs, ws, 2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || sum_out !== 12'h00A || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got ov=%b sum=%h ir=%b expected 1 00a 0", c, out_valid, sum_out, in_ready);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== 12'h00A) begin
      n_fail++;
      $display("FAIL stall_release: got ov=%b busy=%b sum=%h expected 0 0 00a", out_valid, busy, sum_out);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || sum_out !== 12'h00A) begin
      n_fail++; $display("FAIL idle_retain: got busy=%b sum=%h expected 0 00a", busy, sum_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] xs[4] = '{5'd1, 5'd1, 5'd1, 5'd1};
    logic [5:0] ws[4] = '{6'd2, 6'd2, 6'd2, 6'd2};
    out_ready = 1'b1;
    do_start();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_in = 5'd31; w_in = 6'd31;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || sum_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_acc: got ov=%b ir=%b busy=%b sum=%h expected 0 0 0 000",
               out_valid, in_ready, busy, sum_out);
    end
    do_start();
    feed(xs, ws, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 12'h008) begin
      n_fail++; $display("FAIL after_reset_run: got ov=%b sum=%h expected 1 008", out_valid, sum_out);
    end
    // Abort from DONE: result is dropped without a handshake.
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_in_done: got ov=%b busy=%b sum=%h expected 0 0 000", out_valid, busy, sum_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_per_step_clamp();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
